// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, command encodings and the serial frame layout
// used by both the frame encoder and the frame decoder.
package bus_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;
  localparam int CMD_WIDTH  = 3;

  localparam logic [CMD_WIDTH-1:0] CMD_READ        = 3'd0;
  localparam logic [CMD_WIDTH-1:0] CMD_WRITE       = 3'd1;
  localparam logic [CMD_WIDTH-1:0] CMD_SPLIT_START = 3'd2;
  localparam logic [CMD_WIDTH-1:0] CMD_SPLIT_END   = 3'd3;

  // Field order is the wire order: start goes out first, stop last.
  typedef struct packed {
    logic                  start;
    logic [CMD_WIDTH-1:0]  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  parity;
    logic                  stop;
  } serial_frame_t;

  localparam int FRAME_BITS = $bits(serial_frame_t);

  function automatic logic frame_parity(input logic [CMD_WIDTH-1:0]  cmd,
                                        input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [DATA_WIDTH-1:0] data);
    return ^{cmd, addr, data};
  endfunction

endpackage

// File: rtl/frame_encoder_bit_tick_gen.sv
// Clocks-per-bit divider: while enabled, emits a one-cycle tick on the last
// clock of every bit period. Shared with the receive path.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // Held at zero while disabled so every bit period starts aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/frame_encoder.sv
// Serial frame transmitter: latches a bus request, presents the parallel frame
// for one cycle, then shifts it out MSB first followed by an idle-low gap.
module frame_encoder
  import bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CMD_WIDTH-1:0]  req_cmd_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  parity_inject_i,
  output logic                  frame_valid_o,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // state    | meaning
  // TX_IDLE  | ready for a request, line low
  // TX_SHIFT | shifting the latched frame out, MSB first
  // TX_GAP   | line held low for GAP_BITS bit periods
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  localparam int BW = $clog2(FRAME_BITS);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  tx_state_e             state_q;
  serial_frame_t         frame_q;
  serial_frame_t         frame_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [GW-1:0]         gap_cnt_q;
  logic                  frame_valid_q;
  logic                  tx_q;
  logic                  done_q;
  logic                  accept;
  logic                  tick;

  assign accept = req_valid_i && (state_q == TX_IDLE);

  always_comb begin
    frame_d        = '0;
    frame_d.start  = 1'b1;
    frame_d.cmd    = req_cmd_i;
    frame_d.addr   = req_addr_i;
    frame_d.data   = req_wdata_i;
    frame_d.parity = frame_parity(req_cmd_i, req_addr_i, req_wdata_i) ^ parity_inject_i;
    frame_d.stop   = 1'b1;
  end

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   ((state_q == TX_SHIFT) || (state_q == TX_GAP)),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= TX_IDLE;
      frame_q       <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      tx_q          <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b0;
          if (accept) begin
            frame_q       <= frame_d;
            shift_q       <= frame_d;
            frame_valid_q <= 1'b1;
            tx_q          <= frame_d.start;
            bit_cnt_q     <= '0;
            state_q       <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              tx_q      <= 1'b0;
              done_q    <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= (GAP_BITS > 0) ? TX_GAP : TX_IDLE;
            end else begin
              // Next bit is already at [MSB-1] of the current shift image.
              tx_q      <= shift_q[FRAME_BITS-2];
              shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        TX_GAP: begin
          tx_q <= 1'b0;
          if (tick) begin
            if (int'(gap_cnt_q) == GAP_BITS - 1) begin
              state_q <= TX_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = (state_q == TX_IDLE);
  assign busy_o        = !req_ready_o;
  assign frame_valid_o = frame_valid_q;
  assign frame_o       = frame_q;
  assign tx_o          = tx_q;
  assign done_o        = done_q;

endmodule

// File: doc/frame_encoder.md
Name: frame_encoder

Overview:
Transmit-side counterpart of the serial bus frame decoder. Accepts a bus request (cmd, addr, data) over a valid/ready handshake and builds a serial_frame_t with start, stop and parity fields. Shifts the frame out on a single serial line at a fixed clocks-per-bit rate. Also presents the parallel frame with a one-cycle valid pulse, so a bench can loop it straight back into the decoder.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal values are 1 or more.
GAP_BITS, 1, idle bit periods (line low) enforced after each stop bit before the next request is accepted; legal values are 0 or more.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  encoder can accept a request
req_cmd_i  input  CMD_WIDTH  command (bus_pkg cmd encoding)
req_addr_i  input  ADDR_WIDTH  target address
req_wdata_i  input  DATA_WIDTH  write data
parity_inject_i  input  1  sampled at acceptance; inverts the parity bit of that frame
frame_valid_o  output  1  one-cycle pulse: frame_o has been updated
frame_o  output  $bits(serial_frame_t)  last built frame
tx_o  output  1  serial line; idles low
busy_o  output  1  high from acceptance until the end of the gap
done_o  output  1  one-cycle pulse when the stop-bit period ends

Behaviour:
- Reset values: req_ready_o=1, frame_valid_o=0, frame_o='0, tx_o=0, busy_o=0, done_o=0. State is TX_IDLE.
- Frame build on accept (req_valid_i && req_ready_o):
  - start=1, stop=1.
  - cmd, addr, data copied from the request inputs.
  - parity = ^{cmd,addr,data} (even parity), XOR parity_inject_i.
- Cycle after accept: frame_o updated, frame_valid_o=1 for exactly one cycle, state goes to TX_SHIFT.
- Bit order: MSB of the packed serial_frame_t first, i.e. the start bit goes out first and the stop bit last.
- TX_SHIFT:
  - tx_o holds the current bit for exactly CLKS_PER_BIT cycles. A bit counter runs 0..FRAME_BITS-1; a clock-divider counter runs 0..CLKS_PER_BIT-1.
  - The first bit is driven in the first TX_SHIFT cycle.
  - After the last cycle of the stop bit: done_o=1 for one cycle and tx_o=0.
  - If GAP_BITS>0, go to TX_GAP; otherwise go to TX_IDLE.
- TX_GAP: tx_o=0 for GAP_BITS*CLKS_PER_BIT cycles, then TX_IDLE.
- req_ready_o = (state==TX_IDLE). busy_o = !req_ready_o.
- A request held during busy is not lost: valid stays asserted and is accepted in the first TX_IDLE cycle.
- Back-to-back: the minimum accept-to-accept spacing is 1 + (FRAME_BITS+GAP_BITS)*CLKS_PER_BIT cycles.
- Request inputs are registered at acceptance. Changes to them after acceptance do not affect the frame in flight.
- Reset mid-frame: tx_o drops to 0 asynchronously, the partial frame is abandoned, done_o is not pulsed, and state returns to TX_IDLE.
- Illegal state: recover to TX_IDLE with tx_o=0.
- CLKS_PER_BIT=1 must work: one bit per cycle with no dead cycles between bits.

Decomposition:
- bus_pkg (shared package):
  - Already holds ADDR_WIDTH, DATA_WIDTH, the cmd encodings (CMD_WRITE, CMD_SPLIT_START, ...) and serial_frame_t.
  - Add CMD_WIDTH, FRAME_BITS = $bits(serial_frame_t), and function frame_parity(cmd, addr, data).
- Encoder-local: the tx state enum (TX_IDLE, TX_SHIFT, TX_GAP).
- One natural sub-module: bit_tick_gen. It is the CLKS_PER_BIT divider with an enable and a one-cycle tick output, and is reusable by the receive path.

Test Plan:
- Single write, CLKS_PER_BIT=4, cmd=CMD_WRITE, addr=0x1234, data=0xA5 -> frame_o start=1, stop=1, parity=^{cmd,0x1234,0xA5}. tx_o reproduces frame_o MSB-first, 4 cycles per bit. done_o fires 1+FRAME_BITS*4 cycles after accept.
- Loopback: frame_o/frame_valid_o into frame_decoder (parity_err_i=0) -> decoder valid_o=1, addr_o=0x1234, wdata_o=0xA5, we_o=1, err_o=0.
- parity_inject_i=1 on accept -> frame_o.parity inverted; decoder with recomputed parity check flags err_o=1 and does not raise valid_o.
- Backpressure: second request (addr=0x0042, data=0x3C) asserted 10 cycles after the first accept -> req_ready_o stays 0 until the gap ends, then accepted. Accept spacing is exactly 1+(FRAME_BITS+1)*4 cycles.
- Reset asserted mid-frame at bit 7 -> tx_o=0 immediately, no done_o pulse, req_ready_o=1 after release. The next request is sent intact.
- CLKS_PER_BIT=1, GAP_BITS=0, continuous valid with 3 requests -> three contiguous frames, one bit per cycle, three done_o pulses spaced FRAME_BITS+1 cycles apart.
